// File: rtl/conv_gatherer.sv
`default_nettype none
// ============================================================================
// Module   : conv_gatherer
// Purpose  : Collects a filter-major convolution result map (all positions of
//            filter 0, then filter 1, ...) and re-emits it time-major: one
//            NUM_FILTERS-lane vector per frame position, with valid/last/ready.
// Options  : define GATHER_RELU_EN to clamp negative results to zero on write.
// Revision : 1.0 - initial release
// ============================================================================
module conv_gatherer #(
  parameter int BW          = 8,
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [BW-1:0]               data_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic [NUM_FILTERS*BW-1:0]   data_o,
  output logic                        valid_o,
  output logic                        last_o,
  input  logic                        ready_i,
  output logic                        err_o
);

  localparam int POS_W  = (FRAME_LEN   > 1) ? $clog2(FRAME_LEN)   : 1;
  localparam int FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int VEC_W  = NUM_FILTERS * BW;
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUM_FILTERS - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [POS_W-1:0]   pos;
  logic [FILT_W-1:0]  filt;
  logic [POS_W-1:0]   rd_addr;
  logic [POS_W-1:0]   rd_idx;
  logic               in_accept;
  logic               out_accept;
  logic               final_beat;
  logic [BW-1:0]      wr_data;
  logic [NUM_FILTERS-1:0] lane_we;
  logic [VEC_W-1:0]   rd_vec;

  // Result map: one entry per position, one lane per filter. Not reset.
  logic [VEC_W-1:0]   mem [FRAME_LEN];

  // The last input beat of the frame is the last position of the last filter.
  assign final_beat = (pos == POS_LAST) && (filt == FILT_LAST);

`ifdef GATHER_RELU_EN
  // Negative results are clamped to zero before they are stored.
  assign wr_data = data_i[BW-1] ? '0 : data_i;
`else
  assign wr_data = data_i;
`endif

  // Each incoming beat belongs to exactly one lane: the current filter.
  generate
    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane_we
      assign lane_we[f] = in_accept && (filt == FILT_W'(f));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= FILL;
    else       state <= state_next;
  end

  // Next-state and handshake decode: input is only taken while filling.
  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    in_accept  = 1'b0;
    out_accept = 1'b0;
    case (state)
      FILL: begin
        ready_o   = 1'b1;
        in_accept = valid_i;
        if (in_accept && final_beat) state_next = DRAIN;
      end
      DRAIN: begin
        out_accept = valid_o & ready_i;
        if (out_accept && (rd_addr == POS_LAST)) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Per-lane buffer write at the current (position, filter).
  always_ff @(posedge clk_i) begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      if (lane_we[f]) mem[pos][f*BW +: BW] <= wr_data;
    end
  end

  // Entry to present next; the lane being written this cycle is forwarded so
  // the first vector is correct even when its last lane lands on the final beat.
  always_comb begin
    rd_idx = '0;
    if (state == DRAIN && rd_addr != POS_LAST) rd_idx = rd_addr + 1'b1;
    rd_vec = mem[rd_idx];
    for (int f = 0; f < NUM_FILTERS; f++) begin
      if (lane_we[f] && (pos == rd_idx)) rd_vec[f*BW +: BW] = wr_data;
    end
  end

  // Write-side counters; the beat count alone defines the frame boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos  <= '0;
      filt <= '0;
    end else if (in_accept) begin
      if (final_beat) begin
        pos  <= '0;
        filt <= '0;
      end else if (pos == POS_LAST) begin
        pos  <= '0;
        filt <= filt + 1'b1;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

  // Sticky framing error: last_i must coincide with the final beat only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_o <= 1'b0;
    else if (in_accept && (final_beat != last_i)) err_o <= 1'b1;
  end

  // Registered output stage; holds while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
      rd_addr <= '0;
    end else if (in_accept && final_beat) begin
      valid_o <= 1'b1;
      data_o  <= rd_vec;
      last_o  <= (rd_idx == POS_LAST);
      rd_addr <= '0;
    end else if (out_accept) begin
      if (rd_addr == POS_LAST) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
        rd_addr <= '0;
      end else begin
        data_o  <= rd_vec;
        last_o  <= (rd_idx == POS_LAST);
        rd_addr <= rd_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_gatherer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_gatherer
// Purpose  : Self-checking bench for conv_gatherer (FRAME_LEN=4, 2 filters,
//            8-bit). Honours GATHER_RELU_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_gatherer;

  localparam int BW  = 8;
  localparam int FL  = 4;
  localparam int NF  = 2;
  localparam int OW  = NF * BW;
  localparam int TOT = FL * NF;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [BW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic          ready_o;
  logic [OW-1:0] data_o;
  logic          valid_o;
  logic          last_o;
  logic          ready_i = 1'b1;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: beats of the frame in arrival order.
  logic [BW-1:0] frame_in [TOT];
  int            fill_cnt = 0;
  logic          err_exp  = 1'b0;
  logic [OW-1:0] expq [$];

  conv_gatherer #(.BW(BW), .FRAME_LEN(FL), .NUM_FILTERS(NF)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .last_o(last_o), .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] d);
`ifdef GATHER_RELU_EN
    return ($signed(d) < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Beat b of a frame is filter b/FL at position b%FL; output p gathers lane f
  // from beat f*FL+p.
  task automatic model_accept(input logic [BW-1:0] d, input logic l);
    logic [OW-1:0] v;
    if ((fill_cnt == TOT - 1) != l) err_exp = 1'b1;
    frame_in[fill_cnt] = d;
    fill_cnt++;
    if (fill_cnt == TOT) begin
      for (int p = 0; p < FL; p++) begin
        v = '0;
        for (int f = 0; f < NF; f++) v[f*BW +: BW] = relu(frame_in[f*FL + p]);
        expq.push_back(v);
      end
      fill_cnt = 0;
    end
  endtask

  task automatic push(input logic [BW-1:0] d, input logic l);
    bit got = 0;
    data_i = d; last_i = l; valid_i = 1'b1;
    for (int g = 0; g < 300 && !got; g++) begin
      @(negedge clk);
      if (fill_cnt > 0) chk("ready_in_fill", ready_o, 1);
      chk("err_o", err_o, err_exp);
      got = ready_o;
      @(posedge clk); #1;
    end
    chk("push_timeout", got, 1);
    valid_i = 1'b0; last_i = 1'b0;
    model_accept(d, l);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (fill_cnt > 0) chk("ready_idle", ready_o, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic push_frame(input logic [BW-1:0] base, input int last_at);
    for (int b = 0; b < TOT; b++) push(base + BW'(b + 1), b == last_at);
  endtask

  // Consume one output map; ends one edge after the final output is taken.
  task automatic drain(input int st_a, input int st_n, input bit rnd);
    int c = 0;
    int idx = 0;
    logic [OW-1:0] e;
    while (idx < FL && c < 200) begin
      if (rnd) ready_i = ($urandom_range(0, 3) != 0);
      else     ready_i = !(c >= st_a && c < st_a + st_n);
      @(negedge clk);
      e = (expq.size() > 0) ? expq[0] : '0;
      chk("valid_o", valid_o, 1);
      chk("data_o", data_o, e);
      chk("last_o", last_o, idx == FL - 1);
      chk("ready_in_drain", ready_o, 0);
      if (c == 0) chk("err_o_drain", err_o, err_exp);
      if (ready_i) begin
        if (expq.size() > 0) void'(expq.pop_front());
        idx++;
      end
      @(posedge clk); #1;
      c++;
    end
    chk("drain_timeout", idx, FL);
    ready_i = 1'b1;
    @(negedge clk);
    chk("valid_after", valid_o, 0);
    chk("last_after", last_o, 0);
    chk("ready_after", ready_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", ready_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    fill_cnt = 0; err_exp = 1'b0; expq.delete();
    @(negedge clk);
    chk("post_rst_valid", valid_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", ready_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Basic transpose
    push_frame(8'h00, TOT - 1);
    chk("basic_first_vec", expq[0], 16'h0501);
    drain(0, 0, 0);

    // Backpressure while the second vector is presented
    push_frame(8'h00, TOT - 1);
    drain(1, 3, 0);

    // Input stall mid-frame
    for (int b = 0; b < 4; b++) push(BW'(b + 1), 1'b0);
    idle(5);
    for (int b = 4; b < TOT; b++) push(BW'(b + 1), b == TOT - 1);
    drain(0, 0, 0);

    // Early last_i, then a frame with no last_i
    push_frame(8'h00, 2);
    drain(0, 0, 0);
    push_frame(8'h30, -1);
    drain(0, 0, 0);
    chk("err_sticky", err_o, 1);

    // Reset mid-fill, then a fresh frame
    for (int b = 0; b < 5; b++) push(BW'(8'h40 + b), 1'b0);
    do_reset();
    push_frame(8'h10, TOT - 1);
    chk("rst_frame_first_vec", expq[0], 16'h1511);
    drain(0, 0, 0);
    chk("rst_frame_err", err_o, 0);

    // Back-to-back frames with valid_i held high through the drain
    push_frame(8'h20, TOT - 1);
    data_i = 8'hF0; last_i = 1'b0; valid_i = 1'b1;
    drain(0, 0, 0);
    model_accept(8'hF0, 1'b0);
    for (int b = 1; b < TOT; b++) push(BW'(8'h50 + b), b == TOT - 1);
    drain(0, 0, 0);

    // Randomized frames with random gaps, backpressure and occasional bad last_i
    for (int fr = 0; fr < 6; fr++) begin
      for (int b = 0; b < TOT; b++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        push(BW'($urandom), (b == TOT - 1) ^ ($urandom_range(0, 9) == 0));
      end
      drain(0, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_gatherer.md
Name: conv_gatherer

Overview:
- Consumer end of the recycler/convolution path. The recycler replays a frame NUM_FILTERS times, so conv results arrive filter-major: all FRAME_LEN positions for filter 0, then all for filter 1, and so on.
- This block buffers one full result map and re-emits it time-major: one vector per frame position, holding all NUM_FILTERS results.
- The output feeds the next layer as a COLUMN-style stream with valid/last/ready.

Parameters:
- BW, 8, bitwidth of one conv result (signed).
- FRAME_LEN, 50, positions per frame; output vectors per frame.
- NUM_FILTERS, 8, filters per frame; lanes per output vector.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- data_i  input  BW  signed conv result for the current (filter, position).
- valid_i  input  1  data_i valid.
- last_i  input  1  marks the final input beat of a frame.
- ready_o  output  1  block can accept input.
- data_o  output  NUM_FILTERS*BW  time-major vector; lane f = data_o[f*BW +: BW].
- valid_o  output  1  data_o valid.
- last_o  output  1  marks the final output vector (position FRAME_LEN-1).
- ready_i  input  1  downstream accepts.
- err_o  output  1  sticky: last_i misplaced or missing.

Behaviour:
- Reset (async, rst_i=1):
  - state=FILL; pos, filt and rd_addr counters = 0.
  - valid_o=0, last_o=0, data_o=0, err_o=0, ready_o=1.
  - Buffer contents are not reset.
- Buffer: FRAME_LEN entries x NUM_FILTERS*BW, with a per-lane write enable.
- Input accept: valid_i & ready_o.
- FILL state (ready_o=1):
  - Each accept writes data_i into entry pos, lane filt.
  - pos increments. When pos==FRAME_LEN-1, pos wraps to 0 and filt increments.
  - On the accept with filt==NUM_FILTERS-1 and pos==FRAME_LEN-1 (beat NUM_FILTERS*FRAME_LEN): go to DRAIN and clear pos and filt.
- last_i checking:
  - last_i on an accepted beat other than the final one sets err_o. Counting continues; an early last_i does not end the frame.
  - Final beat accepted with last_i=0 also sets err_o.
  - The beat count alone governs frame boundaries.
- DRAIN state (ready_o=0):
  - Registered output stage. valid_o rises the cycle after the final input accept, with data_o = entry 0.
  - On each output accept (valid_o & ready_i): rd_addr increments and the next entry is presented the following cycle, giving 1 vector/cycle under continuous ready_i.
  - When valid_o & !ready_i: data_o, valid_o and last_o hold stable.
  - last_o=1 exactly with entry FRAME_LEN-1.
  - When that vector is accepted: valid_o=0 next cycle, state returns to FILL, ready_o=1 the same cycle as valid_o falls.
- Lane packing: filter f occupies bits [f*BW +: BW]; filter 0 is in the LSBs.
- No arithmetic on data. Values pass through bit-exact, except under the optional feature.
- Counter widths: $clog2 of the range, with a minimum of 1.
- Input during DRAIN: ignored, because ready_o=0. valid_i held high upstream is accepted once FILL resumes.
- Reset mid-operation: immediately returns to the reset values above. A partially filled frame is discarded; there is no recovery of buffer contents.
- err_o clears only on reset.

Optional Feature:
- GATHER_RELU_EN.
- Defined: before the write, negative data_i (MSB=1) is stored as 0; non-negative values are stored unchanged.
- Undefined: data_i is stored unchanged.
- err_o and handshake behaviour are identical in both cases.

Test Plan:
- Basic transpose (FRAME_LEN=4, NUM_FILTERS=2, BW=8):
  - Stimulus: inputs 0x01..0x08 in order, last_i on beat 8, ready_i=1.
  - Required: outputs 0x0501, 0x0602, 0x0703, 0x0804; valid_o starts 1 cycle after beat 8; last_o on the 4th output; err_o=0.
- Backpressure:
  - Stimulus: same frame, ready_i low for 3 cycles while output 0x0602 is presented.
  - Required: data_o held at 0x0602 with valid_o=1 for those cycles; no vector dropped or duplicated.
- Input stall:
  - Stimulus: valid_i deasserted for 5 cycles mid-frame.
  - Required: same output sequence as the basic case; ready_o=1 throughout FILL and 0 throughout DRAIN.
- last_i errors:
  - Stimulus: last_i on beat 3.
  - Required: err_o=1 from the cycle after beat 3; frame still completes after beat 8 with correct data.
  - Stimulus: a second frame with last_i never asserted.
  - Required: err_o remains 1.
- Reset mid-fill:
  - Stimulus: rst_i pulse after beat 5, then a fresh frame 0x11..0x18.
  - Required: outputs 0x1511, 0x1612, 0x1713, 0x1814; valid_o=0 during and right after reset; err_o=0.
- Back-to-back frames:
  - Stimulus: two frames with valid_i held high.
  - Required: 8 outputs with last_o on the 4th and 8th. With GATHER_RELU_EN, an input 0xF0 appears as 0x00 in its lane.
